// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared FSM state encoding and PIO register map for the key IRQ service controller
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_CLR,
        ST_PUSH
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/key_evt_fifo.sv
// rtl/key_evt_fifo.sv - synchronous show-ahead event FIFO holding captured key-edge bits
module key_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/key_irq_service_ctrl.sv
// rtl/key_irq_service_ctrl.sv - bus master that programs the key PIO mask, services its irq and queues key events
module key_irq_service_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int              KEYS       = 4,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [KEYS-1:0] RESET_MASK = 4'hF
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [1:0]      avm_address,
    output logic            avm_chipselect,
    output logic            avm_write_n,
    output logic [31:0]     avm_writedata,
    input  logic [31:0]     avm_readdata,
    input  logic            pio_irq,
    input  logic            enable,
    input  logic [KEYS-1:0] cfg_mask,
    input  logic            cfg_mask_valid,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [KEYS-1:0] evt_keys,
    output logic            evt_overflow,
    input  logic            ovf_clr,
    output logic            busy
);

    state_t          state;
    state_t          state_nxt;
    logic [KEYS-1:0] shadow_mask;
    logic [KEYS-1:0] cap;
    logic [KEYS-1:0] eff_mask;
    logic [KEYS-1:0] rd_keys;
    logic [1:0]      addr_c;
    logic            wr_c;
    logic [KEYS-1:0] wdata_c;
    logic            push_c;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ovf_set;
    logic            unused_rd;

    assign eff_mask  = cfg_mask_valid ? cfg_mask : RESET_MASK;
    assign rd_keys   = avm_readdata[KEYS-1:0];
    assign unused_rd = ^avm_readdata[31:KEYS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            shadow_mask  <= '0;
            cap          <= '0;
            evt_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)    shadow_mask <= eff_mask;
            if (state == ST_RD_DATA) cap <= rd_keys;
            // A drop in the same cycle as a clear request wins, so no loss goes unreported
            if (ovf_set)      evt_overflow <= 1'b1;
            else if (ovf_clr) evt_overflow <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_c    = ADDR_DATA;
        wr_c      = 1'b0;
        wdata_c   = '0;
        push_c    = 1'b0;
        case (state)
            ST_INIT: begin
                addr_c    = ADDR_MASK;
                wr_c      = 1'b1;
                wdata_c   = eff_mask;
                state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (eff_mask != shadow_mask)  state_nxt = ST_INIT;
                else if (pio_irq && enable)   state_nxt = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                addr_c    = ADDR_EDGE;
                state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                addr_c    = ADDR_EDGE;
                state_nxt = (rd_keys == '0) ? ST_IDLE : ST_CLR;
            end
            ST_CLR: begin
                // Writing back only the bits read keeps edges that arrived after the read
                addr_c    = ADDR_EDGE;
                wr_c      = 1'b1;
                wdata_c   = cap;
                state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                push_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Bus outputs are forced idle while reset is asserted, even though the state sits in INIT
    assign avm_address    = reset_n ? addr_c : ADDR_DATA;
    assign avm_chipselect = reset_n && wr_c;
    assign avm_write_n    = !(reset_n && wr_c);
    assign avm_writedata  = reset_n ? {{(32-KEYS){1'b0}}, wdata_c} : 32'd0;
    assign busy           = (state != ST_IDLE);

    assign ovf_set   = push_c && fifo_full && !evt_ready;
    assign evt_valid = !fifo_empty;

    key_evt_fifo #(
        .WIDTH (KEYS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (push_c),
        .push_data (cap),
        .pop       (evt_ready),
        .head      (evt_keys),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
